// File: rtl/key_tone_scheduler.sv
// Eight-key tone scheduler. It synchronizes and debounces the keys, picks the
// note to sound, and hands the note's divider to the tone generator with a
// load/ready handshake.
module key_tone_scheduler #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DB_W            = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  key,
  input  logic        enable,
  input  logic        tone_ready,
  output logic        load_req,
  output logic [17:0] divider,
  output logic [2:0]  note_idx,
  output logic        tone_valid,
  output logic        active
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] PLAY = 2'd2;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0]      sync1, sync2, db, db_d, press, release_ev;
  logic [DB_W-1:0] cnt [8];
  logic            sel_valid;
  logic [2:0]      sel_idx, press_hi, held_lo;
  logic [1:0]      state, next_state;
  logic            reload, changed;

  function automatic logic [17:0] div_of(input logic [2:0] idx);
    case (idx)
      3'd0:    div_of = 18'd191113;
      3'd1:    div_of = 18'd170262;
      3'd2:    div_of = 18'd151686;
      3'd3:    div_of = 18'd143173;
      3'd4:    div_of = 18'd127551;
      3'd5:    div_of = 18'd113636;
      3'd6:    div_of = 18'd101239;
      default: div_of = 18'd95557;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
    end
  end

  // Debounced level flips only after DEBOUNCE_CYCLES consecutive disagreements.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db   <= '0;
      db_d <= '0;
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
    end else begin
      db_d <= db;
      for (int i = 0; i < 8; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          cnt[i] <= '0;
          db[i]  <= sync2[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press      = db & ~db_d;
  assign release_ev = db_d & ~db;

  always_comb begin
    press_hi = '0;
    held_lo  = '0;
    for (int i = 0; i < 8; i++) if (press[i]) press_hi = 3'(i);
    for (int i = 7; i >= 0; i--) if (db[i]) held_lo = 3'(i);
  end

  // A press always wins over a release arriving in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_valid <= 1'b0;
      sel_idx   <= '0;
    end else if (|press) begin
      sel_valid <= 1'b1;
      sel_idx   <= press_hi;
    end else if (sel_valid && release_ev[sel_idx]) begin
      sel_valid <= |db;
      sel_idx   <= held_lo;
    end
  end

  assign changed = sel_valid && (sel_idx != note_idx);

  always_comb begin
    next_state = state;
    reload     = 1'b0;
    case (state)
      IDLE: if (sel_valid && enable) begin
        next_state = LOAD;
        reload     = 1'b1;
      end
      LOAD: if (tone_ready) begin
        if (changed) begin
          next_state = LOAD;
          reload     = 1'b1;
        end else if (!sel_valid || !enable) begin
          next_state = IDLE;
        end else begin
          next_state = PLAY;
        end
      end
      PLAY: if (!sel_valid || !enable) begin
        next_state = IDLE;
      end else if (changed) begin
        next_state = LOAD;
        reload     = 1'b1;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      divider    <= '0;
      note_idx   <= '0;
      tone_valid <= 1'b0;
      active     <= 1'b0;
    end else begin
      state      <= next_state;
      tone_valid <= (next_state == PLAY) || ((next_state == LOAD) && tone_valid);
      active     <= |db;
      if (reload) begin
        divider  <= div_of(sel_idx);
        note_idx <= sel_idx;
      end
    end
  end

  assign load_req = (state == LOAD);

endmodule

// File: tb/tb_key_tone_scheduler.sv
// Bench for key_tone_scheduler: directed scenarios plus random key/enable/ready
// traffic, all checked cycle by cycle against a behavioural reference model.
module tb_key_tone_scheduler;
  localparam int D = 4;
  localparam int S_IDLE = 0, S_LOAD = 1, S_PLAY = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  key = '0;
  logic        enable = 1'b0;
  logic        tone_ready = 1'b0;
  logic        load_req, tone_valid, active;
  logic [17:0] divider;
  logic [2:0]  note_idx;

  always #5 clk = ~clk;

  key_tone_scheduler #(.DEBOUNCE_CYCLES(D), .DB_W(3)) dut (
    .clk(clk), .reset(reset), .key(key), .enable(enable), .tone_ready(tone_ready),
    .load_req(load_req), .divider(divider), .note_idx(note_idx),
    .tone_valid(tone_valid), .active(active)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: raw keys flow through a two-sample delay, a key's level
  // flips when the last D synchronized samples all disagree with it.
  logic [17:0] tbl [8] = '{18'd191113, 18'd170262, 18'd151686, 18'd143173,
                           18'd127551, 18'd113636, 18'd101239, 18'd95557};
  logic [7:0]  m_s1, m_s2, m_db, m_pp, m_pr;
  logic [7:0]  whist[$];
  logic        m_sel_v, m_tv, m_act;
  logic [2:0]  m_sel_i, m_idx;
  logic [17:0] m_div;
  int          m_state;

  task automatic m_reset();
    m_s1 = '0; m_s2 = '0; m_db = '0; m_pp = '0; m_pr = '0;
    m_sel_v = 1'b0; m_sel_i = '0; m_tv = 1'b0; m_act = 1'b0;
    m_idx = '0; m_div = '0; m_state = S_IDLE;
    whist.delete();
    repeat (D) whist.push_back(8'h00);
  endtask

  task automatic model_step();
    logic       n_sel_v, n_tv, chg, reload, all_diff;
    logic [2:0] n_sel_i;
    logic [7:0] flips, n_db;
    int         n_state;
    if (!reset) begin
      m_reset();
      return;
    end
    n_sel_v = m_sel_v;
    n_sel_i = m_sel_i;
    if (m_pp != 0) begin
      for (int i = 0; i < 8; i++) if (m_pp[i]) n_sel_i = 3'(i);
      n_sel_v = 1'b1;
    end else if (m_sel_v && m_pr[m_sel_i]) begin
      n_sel_v = (m_db != 0);
      n_sel_i = '0;
      for (int i = 7; i >= 0; i--) if (m_db[i]) n_sel_i = 3'(i);
    end
    chg = m_sel_v && (m_sel_i != m_idx);
    reload = 1'b0;
    n_state = m_state;
    if (m_state == S_IDLE) begin
      if (m_sel_v && enable) begin n_state = S_LOAD; reload = 1'b1; end
    end else if (m_state == S_LOAD) begin
      if (tone_ready) begin
        if (chg) begin n_state = S_LOAD; reload = 1'b1; end
        else if (!m_sel_v || !enable) n_state = S_IDLE;
        else n_state = S_PLAY;
      end
    end else begin
      if (!m_sel_v || !enable) n_state = S_IDLE;
      else if (chg) begin n_state = S_LOAD; reload = 1'b1; end
    end
    if (reload) begin
      m_div = tbl[m_sel_i];
      m_idx = m_sel_i;
    end
    n_tv = (n_state == S_PLAY) || ((n_state == S_LOAD) && m_tv);
    whist.push_back(m_s2);
    void'(whist.pop_front());
    flips = '0;
    for (int i = 0; i < 8; i++) begin
      all_diff = 1'b1;
      foreach (whist[k]) if (whist[k][i] == m_db[i]) all_diff = 1'b0;
      flips[i] = all_diff;
    end
    n_db = m_db ^ flips;
    m_pp = flips & n_db;
    m_pr = flips & ~n_db;
    m_act = |m_db;
    m_db = n_db;
    m_s2 = m_s1;
    m_s1 = key;
    m_sel_v = n_sel_v;
    m_sel_i = n_sel_i;
    m_state = n_state;
    m_tv = n_tv;
  endtask

  task automatic compare_all();
    check("load_req", load_req, m_state == S_LOAD);
    check("tone_valid", tone_valid, m_tv);
    check("divider", divider, m_div);
    check("note_idx", note_idx, m_idx);
    check("active", active, m_act);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1 compare_all();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_load(input string tag, output int lat);
    lat = 0;
    while (!load_req && lat < 40) begin
      tick();
      lat++;
    end
    check(tag, load_req, 1);
  endtask

  int lat, hs;

  initial begin
    m_reset();
    run(3);
    check("rst_load_req", load_req, 0);
    check("rst_divider", divider, 0);
    check("rst_active", active, 0);
    reset = 1'b1; enable = 1'b1; tone_ready = 1'b1;

    // Single key: latency and divider.
    key = 8'h20;
    wait_load("lat_to", lat);
    check("press_latency", lat, D + 4);
    check("div_key5", divider, 113636);
    check("idx_key5", note_idx, 5);
    tick();
    check("play_tv", tone_valid, 1);
    key = 8'h00;
    run(15);

    // Short glitch must not be accepted.
    key = 8'h04;
    run(3);
    key = 8'h00;
    for (int i = 0; i < 15; i++) begin
      tick();
      check("glitch_load", load_req, 0);
    end
    check("glitch_active", active, 0);

    // Newest press wins, fallback to lowest held on release.
    key = 8'h01;
    wait_load("k0_to", lat);
    check("div_k0", divider, 191113);
    run(15);
    key = 8'h81;
    hs = 0;
    wait_load("k7_to", lat);
    check("div_k7", divider, 95557);
    for (int i = 0; i < 15; i++) begin
      if (load_req && tone_ready) hs++;
      tick();
    end
    check("hs_k7", hs, 1);
    key = 8'h01;
    hs = 0;
    wait_load("k0b_to", lat);
    check("div_k0b", divider, 191113);
    for (int i = 0; i < 15; i++) begin
      if (load_req && tone_ready) hs++;
      tick();
    end
    check("hs_k0b", hs, 1);
    key = 8'h00;
    run(15);

    // Release during a stalled load: load holds, then goes idle.
    tone_ready = 1'b0;
    key = 8'h02;
    wait_load("stall_to", lat);
    key = 8'h00;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("stall_load", load_req, 1);
      check("stall_div", divider, 170262);
    end
    tone_ready = 1'b1;
    tick();
    check("stall_idle", load_req, 0);
    check("stall_tv", tone_valid, 0);
    run(3);

    // Simultaneous presses, then enable drop in PLAY.
    key = 8'h0C;
    wait_load("sim_to", lat);
    check("sim_idx", note_idx, 3);
    tick();
    check("sim_play", tone_valid, 1);
    enable = 1'b0;
    tick();
    check("dis_tv", tone_valid, 0);
    check("dis_load", load_req, 0);
    enable = 1'b1;
    key = 8'h00;
    run(15);

    // Asynchronous reset in the middle of a load.
    tone_ready = 1'b0;
    key = 8'h40;
    wait_load("rst_to", lat);
    #2 reset = 1'b0;
    #1;
    check("arst_load", load_req, 0);
    check("arst_tv", tone_valid, 0);
    check("arst_div", divider, 0);
    check("arst_idx", note_idx, 0);
    check("arst_act", active, 0);
    m_reset();
    key = 8'h00;
    run(2);
    reset = 1'b1;
    run(3);

    // Random traffic against the model.
    for (int it = 0; it < 250; it++) begin
      case ($urandom_range(0, 3))
        0: key = 8'($urandom);
        1: key = key ^ 8'(1 << $urandom_range(0, 7));
        2: key = 8'h00;
        default: key = key | 8'(1 << $urandom_range(0, 7));
      endcase
      enable = ($urandom_range(0, 7) != 0);
      tone_ready = ($urandom_range(0, 2) != 0);
      run($urandom_range(1, 16));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/key_tone_scheduler.md
KEY_TONE_SCHEDULER -- requirements
Module: key_tone_scheduler

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, consecutive cycles a key level must hold before it is accepted (10 ms at 100 MHz).
REQ-002 Parameter DB_W, default 20, debounce counter width; SHALL satisfy 2^DB_W > DEBOUNCE_CYCLES.
REQ-003 clk  input  1  system clock, 100 MHz.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 key  input  8  raw keyboard levels, 1 = pressed, asynchronous to clk.
REQ-006 enable  input  1  1 = scheduling allowed, 0 = silence requested.
REQ-007 tone_ready  input  1  tone generator accepts a divider this cycle.
REQ-008 load_req  output  1  divider valid, awaiting acceptance.
REQ-009 divider  output  18  half-period count for the tone generator.
REQ-010 note_idx  output  3  index of the key currently scheduled.
REQ-011 tone_valid  output  1  1 = generator is to sound the loaded divider.
REQ-012 active  output  1  1 = at least one debounced key is held.

Function
REQ-013 Each key bit SHALL pass a 2-flop synchronizer before any other use.
REQ-014 Per key: the debounced level SHALL change only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any match clears that key's counter.
REQ-015 Press event = debounced 0->1; release event = debounced 1->0; both are single-cycle.
REQ-016 Divider table, fixed: idx0 191113, idx1 170262, idx2 151686, idx3 143173, idx4 127551, idx5 113636, idx6 101239, idx7 95557 (C4..C5).
REQ-017 Selection: the most recent press wins; for simultaneous presses, the highest index wins.
REQ-018 When the selected key is released, selection SHALL fall back to the lowest-index key still held; if none is held, the target is silence.
REQ-019 FSM states are IDLE, LOAD, PLAY.
REQ-020 IDLE: load_req=0, tone_valid=0; a selection with enable=1 -> LOAD on the next edge.
REQ-021 LOAD: load_req=1; divider and note_idx held stable until load_req & tone_ready are both 1 in the same cycle (accept).
REQ-022 On accept: if the selection changed during LOAD -> LOAD with the new divider; else if target is silence or enable=0 -> IDLE; else -> PLAY.
REQ-023 PLAY: tone_valid=1, load_req=0; a selection change -> LOAD (tone_valid stays 1); silence or enable=0 -> IDLE, tone_valid=0 from the next cycle.
REQ-024 tone_valid SHALL deassert while in LOAD if entered from IDLE, and assert on the first PLAY cycle.
REQ-025 A pending LOAD SHALL never be abandoned: enable=0 or key release during LOAD takes effect only after accept.
REQ-026 A press and a release in the same cycle: the press is applied to selection; the release applies only if it is the selected key and no press occurred.
REQ-027 active = OR of debounced levels, registered.
REQ-028 Latency from a stable raw press to load_req=1 SHALL be exactly DEBOUNCE_CYCLES+4 cycles from IDLE.

Reset
REQ-029 While reset=0: all state IDLE, debounced levels 0, counters 0, load_req=0, tone_valid=0, divider=0, note_idx=0, active=0.
REQ-030 Reset SHALL take effect asynchronously, including mid-LOAD (load_req drops immediately), and release synchronously on clk.

Verification (DEBOUNCE_CYCLES=4 for simulation)
REQ-031 Hold key=0x20, tone_ready=1 -> load_req after 8 cycles, divider=113636, note_idx=5, then PLAY with tone_valid=1.
REQ-032 Glitch key[2] high for 3 cycles -> no debounced change, load_req stays 0.
REQ-033 Hold key 0x01, then add 0x80, release 0x80 -> divider 191113 -> 95557 -> 191113, each via one LOAD handshake.
REQ-034 tone_ready=0 for 10 cycles in LOAD while the key is released -> load_req and divider held, accept completes, then IDLE with tone_valid=0.
REQ-035 Simultaneous press 0x0C -> note_idx=3; enable=0 in PLAY -> IDLE next cycle.
REQ-036 reset=0 asserted mid-LOAD -> load_req=0 with no clock edge; all outputs 0.
